pipe_pattern_gen: RTL and testbench
===================================

Name: pipe_pattern_gen

Overview:
Parametrised wall-column generator for the scrolling playfield. Once per scroll tick it emits one ROWS-bit column: either a pipe with a randomly placed opening, or a blank spacer column. It adds a configurable gap length, a configurable tick rate and a difficulty ramp that narrows the opening as pipes are emitted. It sits between the LFSR random source and the column shift/display logic; the game FSM drives start and over.

Parameters:
ROWS, 8, column height in rows; also the pattern width.
RAND_W, 3, width of the random input.
TICK_DIV, 256, clk cycles per scroll tick (>=2).
GAP_COLS, 3, blank columns emitted after each pipe column (>=0).
OPEN_MAX, 4, opening height of the first pipe, in rows (< ROWS).
OPEN_MIN, 2, floor for the opening height (1..OPEN_MAX).
LEVEL_STEP, 8, pipes emitted per one-row narrowing of the opening (>=1).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  run enable; low = synchronous clear to the idle state
over  in  1  game over; high freezes all state
random  in  RAND_W  random value, sampled on pipe ticks
pattern  out  ROWS  current column; bit i = row i (row 0 = top); 1 = wall
col_tick  out  1  one-cycle pulse in the cycle after pattern updates
pipe_emit  out  1  one-cycle pulse, coincident with col_tick, when the new column is a pipe
opening  out  $clog2(OPEN_MAX+1)  opening height applied to the next pipe
pipe_count  out  8  pipes emitted, saturating at 255

Behaviour:
- Reset (reset=0, asynchronous): pattern=0, col_tick=0, pipe_emit=0, opening=OPEN_MAX, pipe_count=0; tick divider=0, column phase=0, level counter=0.
- start=0 at a clk edge: same clear as reset, applied synchronously. start=0 takes priority over over.
- Tick divider: increments each clk while start=1 and over=0. When it equals TICK_DIV-1 it wraps to 0 and a scroll tick fires on that edge.
- First tick fires TICK_DIV cycles after start rises.
- Column phase runs 0..GAP_COLS and advances on each tick, wrapping to 0.
  - phase 0: pipe column.
  - phases 1..GAP_COLS: blank column, pattern=0.
  - GAP_COLS=0 means every tick emits a pipe.
  - The first tick after clear is phase 0, so it emits a pipe.
- Pipe column:
  - pos = random mod (ROWS-opening+1), computed combinationally from random at the tick edge.
  - Rows pos..pos+opening-1 are 0; all other rows are 1.
  - Example (ROWS=8, opening=4): random=6 gives pos=1, pattern=8'b11100001.
- col_tick is registered and high for exactly one cycle per tick. pipe_emit is high on that same cycle when the column was a pipe.
- Difficulty ramp:
  - On each pipe tick, pipe_count increments (saturating at 255) and the level counter increments.
  - When the level counter reaches LEVEL_STEP it clears, and opening decrements by 1, never below OPEN_MIN.
  - The pipe that triggers the decrement uses the old opening; the new value applies from the next pipe.
- over=1 (with start=1):
  - Divider, phase, pattern, opening, pipe_count and the level counter all hold.
  - col_tick and pipe_emit stay 0.
  - When over deasserts, counting resumes from the held divider value.
- over rising on a tick edge: that tick is suppressed, and no column update occurs.
- Reset asserted mid-operation: immediate clear of all state regardless of clk. After reset releases with start=1, behaviour matches a fresh start.
- All registers are in the clk domain. Outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
1. Reset and idle: reset=0, then reset=1 with start=0 for 20 cycles -> pattern=0, col_tick never pulses, opening=4, pipe_count=0.
2. Basic cadence (TICK_DIV=4, GAP_COLS=3, random=6):
   - raise start -> first col_tick 4 cycles later, with pattern=8'b11100001 and pipe_emit=1.
   - Next 3 ticks -> pattern=0, pipe_emit=0.
   - 5th tick -> pipe again.
3. Opening placement sweep (opening=4): random 0..7 on pipe ticks -> pos = 0,1,2,3,4,0,1,2. Check random=0 gives 8'b11110000 and random=4 gives 8'b00001111.
4. Difficulty ramp (LEVEL_STEP=2, GAP_COLS=0, TICK_DIV=2, random=0):
   - Pipes 1-2 -> 8'b11110000. Pipes 3-4 -> 8'b11111000. Pipes 5 onward -> 8'b11111100.
   - opening stops at 2; pipe_count=6 after 6 pipes.
5. Freeze: assert over for 10 cycles mid-gap -> pattern, pipe_count and opening are unchanged, and col_tick=0. Deassert over -> the next tick arrives after the remaining divider count.
6. Clear priority and async reset: start=0 together with over=1 -> state clears. Pulse reset low for 3 ns between clk edges -> pattern=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/pipe_pattern_if.sv
// pipe_pattern_if: game-side control/random inputs and column outputs of the pipe generator.
// Ports: i_start, i_over, i_random (into the generator); o_pattern, o_col_tick,
//        o_pipe_emit, o_opening, o_pipe_count (out of the generator).
interface pipe_pattern_if #(
    parameter int ROWS   = 8,
    parameter int RAND_W = 3,
    parameter int OPEN_W = 3
);
    logic              i_start;
    logic              i_over;
    logic [RAND_W-1:0] i_random;
    logic [ROWS-1:0]   o_pattern;
    logic              o_col_tick;
    logic              o_pipe_emit;
    logic [OPEN_W-1:0] o_opening;
    logic [7:0]        o_pipe_count;

    modport master (
        output i_start, i_over, i_random,
        input  o_pattern, o_col_tick, o_pipe_emit, o_opening, o_pipe_count
    );

    modport slave (
        input  i_start, i_over, i_random,
        output o_pattern, o_col_tick, o_pipe_emit, o_opening, o_pipe_count
    );
endinterface

// File: rtl/pipe_pattern_gen.sv
// pipe_pattern_gen: per scroll tick emits a pipe column with a random opening or a blank spacer,
// narrowing the opening as pipes are emitted.
// Ports: clk, reset (async active-low), bus (pipe_pattern_if.slave: start/over/random in,
//        pattern/col_tick/pipe_emit/opening/pipe_count out, all registered).
module pipe_pattern_gen #(
    parameter int ROWS       = 8,
    parameter int RAND_W     = 3,
    parameter int TICK_DIV   = 256,
    parameter int GAP_COLS   = 3,
    parameter int OPEN_MAX   = 4,
    parameter int OPEN_MIN   = 2,
    parameter int LEVEL_STEP = 8
) (
    input logic           clk,
    input logic           reset,
    pipe_pattern_if.slave bus
);
    localparam int OW = $clog2(OPEN_MAX + 1);
    localparam int DW = $clog2(TICK_DIV);
    localparam int PW = GAP_COLS > 0 ? $clog2(GAP_COLS + 1) : 1;
    localparam int LW = LEVEL_STEP > 1 ? $clog2(LEVEL_STEP) : 1;

    logic [DW-1:0]   r_div;
    logic [PW-1:0]   r_phase;
    logic [LW-1:0]   r_level;
    logic [OW-1:0]   r_open;
    logic [7:0]      r_count;
    logic [ROWS-1:0] r_pattern;
    logic            r_col_tick;
    logic            r_pipe_emit;

    logic            w_tick;
    logic            w_pipe_phase;
    logic [31:0]     w_span;
    logic [31:0]     w_pos;
    logic [ROWS-1:0] w_pipe;

    assign w_tick       = r_div == DW'(TICK_DIV - 1);
    assign w_pipe_phase = r_phase == '0;

    // Opening occupies rows pos..pos+open-1; span guarantees it fits inside the column.
    always_comb begin
        w_span = 32'(ROWS + 1) - 32'(r_open);
        w_pos  = 32'(bus.i_random) % w_span;
        w_pipe = '0;
        for (int i = 0; i < ROWS; i++)
            w_pipe[i] = !(32'(i) >= w_pos && 32'(i) < w_pos + 32'(r_open));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || !bus.i_start) begin
            r_div       <= '0;
            r_phase     <= '0;
            r_level     <= '0;
            r_open      <= OW'(OPEN_MAX);
            r_count     <= '0;
            r_pattern   <= '0;
            r_col_tick  <= 1'b0;
            r_pipe_emit <= 1'b0;
        end else if (bus.i_over) begin
            r_col_tick  <= 1'b0;
            r_pipe_emit <= 1'b0;
        end else begin
            r_col_tick  <= w_tick;
            r_pipe_emit <= w_tick && w_pipe_phase;
            r_div       <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_phase   <= r_phase == PW'(GAP_COLS) ? '0 : r_phase + 1'b1;
                r_pattern <= w_pipe_phase ? w_pipe : '0;
                if (w_pipe_phase) begin
                    if (r_count != 8'hFF)
                        r_count <= r_count + 1'b1;
                    // The triggering pipe already used the old opening; the new one applies next pipe.
                    if (r_level == LW'(LEVEL_STEP - 1)) begin
                        r_level <= '0;
                        if (r_open > OW'(OPEN_MIN))
                            r_open <= r_open - 1'b1;
                    end else begin
                        r_level <= r_level + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.o_pattern    = r_pattern;
    assign bus.o_col_tick   = r_col_tick;
    assign bus.o_pipe_emit  = r_pipe_emit;
    assign bus.o_opening    = r_open;
    assign bus.o_pipe_count = r_count;
endmodule

// File: tb/tb_pipe_pattern_gen.sv
// tb_pipe_pattern_gen: directed bench for pipe_pattern_gen with two configurations.
module tb_pipe_pattern_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipe_pattern_if #(.ROWS(8), .RAND_W(3), .OPEN_W(3)) a_if ();
    pipe_pattern_if #(.ROWS(8), .RAND_W(3), .OPEN_W(3)) b_if ();

    pipe_pattern_gen #(.TICK_DIV(4), .GAP_COLS(3), .LEVEL_STEP(20)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    pipe_pattern_gen #(.TICK_DIV(2), .GAP_COLS(0), .LEVEL_STEP(2)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(input bit sel, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel ? b_if.o_col_tick : a_if.o_col_tick) && n < 50);
        if (n >= 50) begin
            n_cmp++;
            n_err++;
            $error("FAIL tick_timeout: observed no col_tick expected one within 50 cycles");
        end
    endtask

    initial begin
        int n;
        int pulses;
        logic [7:0] e;
        a_if.i_start = 1'b0; a_if.i_over = 1'b0; a_if.i_random = '0;
        b_if.i_start = 1'b0; b_if.i_over = 1'b0; b_if.i_random = '0;
        // 1: reset and idle
        #2 reset = 1'b0;
        #2;
        check("rst_pattern", 32'(a_if.o_pattern), 32'h00);
        check("rst_col_tick", 32'(a_if.o_col_tick), 32'h0);
        check("rst_opening", 32'(a_if.o_opening), 32'd4);
        check("rst_count", 32'(a_if.o_pipe_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_if.o_col_tick) pulses++;
        end
        check("idle_pulses", 32'(pulses), 32'd0);
        check("idle_pattern", 32'(a_if.o_pattern), 32'h00);
        check("idle_opening", 32'(a_if.o_opening), 32'd4);
        // 2: basic cadence
        a_if.i_random = 3'd6;
        a_if.i_start = 1'b1;
        wait_tick(1'b0, n);
        check("first_latency", 32'(n), 32'd4);
        check("first_pattern", 32'(a_if.o_pattern), 32'hE1);
        check("first_emit", 32'(a_if.o_pipe_emit), 32'h1);
        @(negedge clk);
        check("tick_width", 32'(a_if.o_col_tick), 32'h0);
        wait_tick(1'b0, n);
        check("gap_latency", 32'(n), 32'd3);
        for (int g = 0; g < 3; g++) begin
            if (g > 0) wait_tick(1'b0, n);
            check("gap_pattern", 32'(a_if.o_pattern), 32'h00);
            check("gap_emit", 32'(a_if.o_pipe_emit), 32'h0);
        end
        wait_tick(1'b0, n);
        check("fifth_pattern", 32'(a_if.o_pattern), 32'hE1);
        check("fifth_emit", 32'(a_if.o_pipe_emit), 32'h1);
        check("fifth_count", 32'(a_if.o_pipe_count), 32'd2);
        // 3: opening placement sweep
        for (int r = 0; r < 8; r++) begin
            for (int g = 0; g < 3; g++) wait_tick(1'b0, n);
            a_if.i_random = 3'(r);
            wait_tick(1'b0, n);
            e = ~(8'h0F << (r % 5));
            check("sweep_pattern", 32'(a_if.o_pattern), 32'(e));
            check("sweep_emit", 32'(a_if.o_pipe_emit), 32'h1);
        end
        check("sweep_count", 32'(a_if.o_pipe_count), 32'd10);
        // 5: freeze mid-gap
        wait_tick(1'b0, n);
        @(negedge clk);
        a_if.i_over = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_if.o_col_tick) pulses++;
        end
        check("frz_pulses", 32'(pulses), 32'd0);
        check("frz_pattern", 32'(a_if.o_pattern), 32'h00);
        check("frz_count", 32'(a_if.o_pipe_count), 32'd10);
        check("frz_opening", 32'(a_if.o_opening), 32'd4);
        a_if.i_over = 1'b0;
        wait_tick(1'b0, n);
        check("resume_latency", 32'(n), 32'd3);
        check("resume_emit", 32'(a_if.o_pipe_emit), 32'h0);
        // 4: difficulty ramp
        b_if.i_start = 1'b1;
        for (int p = 1; p <= 6; p++) begin
            wait_tick(1'b1, n);
            e = p <= 2 ? 8'hF0 : p <= 4 ? 8'hF8 : 8'hFC;
            check("ramp_pattern", 32'(b_if.o_pattern), 32'(e));
            check("ramp_emit", 32'(b_if.o_pipe_emit), 32'h1);
            check("ramp_opening", 32'(b_if.o_opening), p < 2 ? 32'd4 : p < 4 ? 32'd3 : 32'd2);
        end
        check("ramp_count", 32'(b_if.o_pipe_count), 32'd6);
        // 6: clear priority over freeze
        b_if.i_over = 1'b1;
        b_if.i_start = 1'b0;
        @(negedge clk);
        check("clr_pattern", 32'(b_if.o_pattern), 32'h00);
        check("clr_count", 32'(b_if.o_pipe_count), 32'd0);
        check("clr_opening", 32'(b_if.o_opening), 32'd4);
        // 6: async reset between edges
        a_if.i_random = 3'd6;
        a_if.i_start = 1'b0;
        @(negedge clk);
        a_if.i_start = 1'b1;
        wait_tick(1'b0, n);
        check("pre_rst_pattern", 32'(a_if.o_pattern), 32'hE1);
        #1 reset = 1'b0;
        #2;
        check("async_pattern", 32'(a_if.o_pattern), 32'h00);
        check("async_count", 32'(a_if.o_pipe_count), 32'd0);
        #1 reset = 1'b1;
        wait_tick(1'b0, n);
        check("restart_latency", 32'(n), 32'd4);
        check("restart_pattern", 32'(a_if.o_pattern), 32'hE1);
        check("restart_count", 32'(a_if.o_pipe_count), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
